// File: rtl/nmr_stream_fork.sv
// Buffered fork of one valid/ready stream to NUM_OUT lockstep destinations.
// Ready from the destinations is voted; disagreement is flagged and counted.
module nmr_stream_fork #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_OUT    = 3,
   parameter int DEPTH      = 2,
   parameter int VOTE_MODE  = 1,
   parameter int CNT_WIDTH  = 8,
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int USE_W     = $clog2(DEPTH + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          repeat_i,
   input  logic                          cnt_clr_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [DATA_WIDTH-1:0]         data_i,
   output logic [NUM_OUT-1:0]            valid_o,
   input  logic [NUM_OUT-1:0]            ready_i,
   output logic [NUM_OUT*DATA_WIDTH-1:0] data_o,
   output logic                          error_o,
   output logic [NUM_OUT-1:0]            err_mask_o,
   output logic [CNT_WIDTH-1:0]          err_cnt_o,
   output logic [USE_W-1:0]              usage_o
);

   // Handshake: an element moves on a cycle where valid and ready are both high
   // at the rising edge; valid never depends combinationally on ready.
   localparam int ONES_W = $clog2(NUM_OUT + 1);
   localparam logic [USE_W-1:0]  DEPTH_U = USE_W'(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_P  = PTR_W'(DEPTH - 1);
   localparam logic [ONES_W-1:0] HALF    = ONES_W'(NUM_OUT / 2);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [USE_W-1:0]      usage_q, usage_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic [ONES_W-1:0]     ones;
   logic                  head_valid, vote, push, pop;
   logic [DATA_WIDTH-1:0] head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_P) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      ones = '0;
      for (int i = 0; i < NUM_OUT; i++) ones = ones + ONES_W'(ready_i[i]);
   end

   assign head_valid = (usage_q != '0);
   assign vote       = (VOTE_MODE == 0) ? (&ready_i) : (ones > HALF);
   assign ready_o    = (usage_q < DEPTH_U);
   assign push       = valid_i & ready_o;
   assign pop        = head_valid & vote & ~repeat_i;
   assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

   assign valid_o    = {NUM_OUT{head_valid}};
   assign data_o     = {NUM_OUT{head}};
   assign err_mask_o = {NUM_OUT{head_valid}} & (ready_i ^ {NUM_OUT{vote}});
   assign error_o    = |err_mask_o;
   assign err_cnt_o  = err_cnt_q;
   assign usage_o    = usage_q;

   always_comb begin
      rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      usage_d   = usage_q;
      err_cnt_d = err_cnt_q;
      case ({push, pop})
         2'b10:   usage_d = usage_q + 1'b1;
         2'b01:   usage_d = usage_q - 1'b1;
         default: usage_d = usage_q;
      endcase
      // Clear wins over a coincident error; the count sticks at all-ones.
      if (cnt_clr_i)                 err_cnt_d = '0;
      else if (error_o && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         usage_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         usage_q   <= usage_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: tb/tb_nmr_stream_fork.sv
// Directed bench: majority-vote instance (CNT_WIDTH=8) and a unanimous
// instance (CNT_WIDTH=2) sharing clock and reset, each with its own inputs.
module tb_nmr_stream_fork;

   localparam int DW = 32;
   localparam int NO = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // majority instance
   logic            rep, clr, vin, rdy_o, err;
   logic [DW-1:0]   din;
   logic [NO-1:0]   vout, rin, mask;
   logic [NO*DW-1:0] dout;
   logic [7:0]      cnt;
   logic [1:0]      use_o;

   // unanimous instance
   logic            u_rep, u_clr, u_vin, u_rdy_o, u_err;
   logic [DW-1:0]   u_din;
   logic [NO-1:0]   u_vout, u_rin, u_mask;
   logic [NO*DW-1:0] u_dout;
   logic [1:0]      u_cnt;
   logic [1:0]      u_use;

   nmr_stream_fork #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(2), .VOTE_MODE(1), .CNT_WIDTH(8)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .repeat_i(rep), .cnt_clr_i(clr),
      .valid_i(vin), .ready_o(rdy_o), .data_i(din), .valid_o(vout), .ready_i(rin),
      .data_o(dout), .error_o(err), .err_mask_o(mask), .err_cnt_o(cnt), .usage_o(use_o));

   nmr_stream_fork #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(2), .VOTE_MODE(0), .CNT_WIDTH(2)) u_una (
      .clk_i(clk), .rst_ni(rst_n), .repeat_i(u_rep), .cnt_clr_i(u_clr),
      .valid_i(u_vin), .ready_o(u_rdy_o), .data_i(u_din), .valid_o(u_vout), .ready_i(u_rin),
      .data_o(u_dout), .error_o(u_err), .err_mask_o(u_mask), .err_cnt_o(u_cnt), .usage_o(u_use));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vin = 1'b1; din = 32'hDEAD_BEEF; rin = '0; rep = 0; clr = 0;
      u_vin = 1'b1; u_din = 32'h1234; u_rin = '0; u_rep = 0; u_clr = 0;
      tick(); tick();
      vin = 1'b0; u_vin = 1'b0;
      #1;
      tests++; if (vout !== 3'b000) begin fails++; $display("FAIL reset_valid got %b exp 000", vout); end
      tests++; if (rdy_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", rdy_o); end
      tests++; if (use_o !== 2'd0) begin fails++; $display("FAIL reset_usage got %0d exp 0", use_o); end
      tests++; if (cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
      tests++; if (dout !== '0 || mask !== '0 || err !== 1'b0) begin
         fails++; $display("FAIL reset_data got %h mask %b err %b exp 0", dout, mask, err); end
      tests++; if (u_use !== 2'd0 || u_cnt !== 2'd0) begin
         fails++; $display("FAIL reset_una got use %0d cnt %0d exp 0 0", u_use, u_cnt); end
      rst_n = 1'b1;
      // Push one element, then pulse reset between edges: must be ignored.
      vin = 1'b1; din = 32'h5A;
      tick();
      vin = 1'b0;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      tick();
      tests++; if (use_o !== 2'd1 || dout[DW-1:0] !== 32'h5A) begin
         fails++; $display("FAIL reset_glitch got use %0d data %h exp 1 5a", use_o, dout[DW-1:0]); end
      rin = 3'b111;
      tick();
      tests++; if (use_o !== 2'd0) begin fails++; $display("FAIL reset_drain got %0d exp 0", use_o); end
   endtask

   task automatic test_basic();
      vin = 1'b1; din = 32'hA5; rin = 3'b111;
      #1;
      tests++; if (vout !== 3'b000 || rdy_o !== 1'b1) begin
         fails++; $display("FAIL basic_nobypass got valid %b ready %b exp 000 1", vout, rdy_o); end
      tick();
      vin = 1'b0;
      #1;
      tests++; if (vout !== 3'b111 || use_o !== 2'd1) begin
         fails++; $display("FAIL basic_present got valid %b use %0d exp 111 1", vout, use_o); end
      for (int i = 0; i < NO; i++) begin
         tests++; if (dout[i*DW +: DW] !== 32'hA5) begin
            fails++; $display("FAIL basic_copy%0d got %h exp a5", i, dout[i*DW +: DW]); end
      end
      tick();
      tests++; if (use_o !== 2'd0 || vout !== 3'b000) begin
         fails++; $display("FAIL basic_pop got use %0d valid %b exp 0 000", use_o, vout); end
   endtask

   task automatic test_back_to_back();
      rin = 3'b111; vin = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         din = DW'(k);
         tick();
         tests++; if (dout[DW-1:0] !== DW'(k) || use_o !== 2'd1 || vout !== 3'b111) begin
            fails++; $display("FAIL b2b_%0d got data %h use %0d valid %b exp %h 1 111",
                              k, dout[DW-1:0], use_o, vout, k); end
      end
      vin = 1'b0;
      tick();
      tests++; if (use_o !== 2'd0) begin fails++; $display("FAIL b2b_drain got %0d exp 0", use_o); end
   endtask

   task automatic test_full();
      rin = 3'b000; vin = 1'b1; din = 32'h11;
      tick();
      din = 32'h22;
      tick();
      tests++; if (use_o !== 2'd2 || rdy_o !== 1'b0 || dout[DW-1:0] !== 32'h11) begin
         fails++; $display("FAIL full_state got use %0d ready %b data %h exp 2 0 11", use_o, rdy_o, dout[DW-1:0]); end
      din = 32'h33;
      tick();
      tests++; if (use_o !== 2'd2 || dout[DW-1:0] !== 32'h11) begin
         fails++; $display("FAIL full_refuse got use %0d data %h exp 2 11", use_o, dout[DW-1:0]); end
      vin = 1'b0; rin = 3'b111;
      #1;
      tests++; if (rdy_o !== 1'b0) begin fails++; $display("FAIL full_nocomb got ready %b exp 0", rdy_o); end
      tick();
      tests++; if (rdy_o !== 1'b1 || use_o !== 2'd1 || dout[DW-1:0] !== 32'h22) begin
         fails++; $display("FAIL full_pop1 got ready %b use %0d data %h exp 1 1 22", rdy_o, use_o, dout[DW-1:0]); end
      tick();
      tests++; if (use_o !== 2'd0) begin fails++; $display("FAIL full_pop2 got %0d exp 0", use_o); end
   endtask

   task automatic test_majority();
      rin = 3'b000; vin = 1'b1; din = 32'h33;
      tick();
      vin = 1'b0; rin = 3'b101;
      #1;
      tests++; if (err !== 1'b1 || mask !== 3'b010) begin
         fails++; $display("FAIL maj_mask got err %b mask %b exp 1 010", err, mask); end
      tick();
      tests++; if (use_o !== 2'd0 || cnt !== 8'd1) begin
         fails++; $display("FAIL maj_pop got use %0d cnt %0d exp 0 1", use_o, cnt); end
      tests++; if (err !== 1'b0 || mask !== 3'b000) begin
         fails++; $display("FAIL maj_idle got err %b mask %b exp 0 000", err, mask); end
   endtask

   task automatic test_unanimous_counter();
      u_rin = 3'b000; u_vin = 1'b1; u_din = 32'h33;
      tick();
      u_vin = 1'b0; u_rin = 3'b101;
      #1;
      tests++; if (u_err !== 1'b1 || u_mask !== 3'b101) begin
         fails++; $display("FAIL una_mask got err %b mask %b exp 1 101", u_err, u_mask); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         tests++; if (u_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || u_use !== 2'd1 || u_dout[DW-1:0] !== 32'h33) begin
            fails++; $display("FAIL una_cnt%0d got cnt %0d use %0d data %h exp %0d 1 33",
                              k, u_cnt, u_use, u_dout[DW-1:0], (k > 3) ? 3 : k); end
      end
      u_clr = 1'b1;
      tick();
      tests++; if (u_cnt !== 2'd0) begin fails++; $display("FAIL una_clr got %0d exp 0", u_cnt); end
      u_clr = 1'b0;
      tick();
      tests++; if (u_cnt !== 2'd1) begin fails++; $display("FAIL una_recount got %0d exp 1", u_cnt); end
      u_rin = 3'b111;
      tick();
      tests++; if (u_use !== 2'd0 || u_cnt !== 2'd1) begin
         fails++; $display("FAIL una_drain got use %0d cnt %0d exp 0 1", u_use, u_cnt); end
   endtask

   task automatic test_repeat();
      rin = 3'b000; vin = 1'b1; din = 32'h44;
      tick();
      vin = 1'b0; rin = 3'b111; rep = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++; if (dout[DW-1:0] !== 32'h44 || use_o !== 2'd1 || err !== 1'b0) begin
            fails++; $display("FAIL repeat_hold%0d got data %h use %0d err %b exp 44 1 0",
                              k, dout[DW-1:0], use_o, err); end
         tick();
      end
      rep = 1'b0;
      tests++; if (use_o !== 2'd1 || cnt !== 8'd1) begin
         fails++; $display("FAIL repeat_after got use %0d cnt %0d exp 1 1", use_o, cnt); end
      tick();
      tests++; if (use_o !== 2'd0) begin fails++; $display("FAIL repeat_pop got %0d exp 0", use_o); end
   endtask

   task automatic test_reset_mid();
      rin = 3'b000; vin = 1'b1; din = 32'h77;
      tick(); tick();
      vin = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      tests++; if (use_o !== 2'd0 || vout !== 3'b000 || cnt !== 8'd0 || rdy_o !== 1'b1) begin
         fails++; $display("FAIL reset_mid got use %0d valid %b cnt %0d ready %b exp 0 000 0 1",
                           use_o, vout, cnt, rdy_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_full();
      test_majority();
      test_unanimous_counter();
      test_repeat();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
